// File: rtl/output_serializer_if.sv
// Byte-stream link between the serializer and the output pins.
// master drives the byte and its valid flag; slave returns ready.
interface output_serializer_if;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/output_serializer.sv
// Transmit side of the array multiplier's byte stream.
// Grabs all result words in one cycle into a wide shift buffer, then shifts
// it out least-significant byte first over a valid/ready handshake.
// The frame ends with a one-cycle done pulse.
module output_serializer #(
  parameter int N_WORDS = 9,
  parameter int WORD_W  = 18
) (
  input  logic                        clk,
  input  logic                        reset,      // asynchronous, active low
  input  logic [N_WORDS*WORD_W-1:0]   result_in,
  input  logic                        load,
  output logic                        busy,
  output logic                        done,
  output_serializer_if.master         tx
);

  localparam int BPW       = (WORD_W + 7) / 8;
  localparam int SLOT_W    = BPW * 8;
  localparam int BUF_W     = N_WORDS * SLOT_W;
  localparam int LAST_BYTE = N_WORDS * BPW - 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state_q, state_d;
  logic [4:0]         idx_q, idx_d;
  logic [BUF_W-1:0]   buf_q, buf_d;
  logic               done_q, done_d;
  logic [BUF_W-1:0]   frame_img;

  // Each word sits in its own byte-aligned slot, zero-extended so the pad
  // bits of the top byte go out as 0 and byte order falls out of the layout.
  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_slot
    assign frame_img[gi*SLOT_W +: SLOT_W] = SLOT_W'(result_in[gi*WORD_W +: WORD_W]);
  end

  // Next-state logic: capture in IDLE, shift one byte per accepted transfer in SEND.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    buf_d   = buf_q;
    done_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SEND;
          idx_d   = 5'd0;
          buf_d   = frame_img;
        end
      end
      SEND: begin
        if (tx.data_ready) begin
          // Shifting in zeros leaves the buffer empty once the frame drains.
          buf_d = buf_q >> 8;
          if (idx_q == 5'(LAST_BYTE)) begin
            state_d = IDLE;
            idx_d   = 5'd0;
            done_d  = 1'b1;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset aborts any frame in flight without a done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      idx_q   <= 5'd0;
      buf_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      buf_q   <= buf_d;
      done_q  <= done_d;
    end
  end

  // Outputs come straight from flops, so valid never depends on ready.
  assign tx.data_out   = buf_q[7:0];
  assign tx.data_valid = (state_q == SEND);
  assign busy          = (state_q == SEND);
  assign done          = done_q;

endmodule

// File: tb/tb_output_serializer.sv
// Self-checking bench for output_serializer: directed frames plus random
// data and random backpressure, checked against a byte-list model.
module tb_output_serializer;
  localparam int NW = 9;
  localparam int WW = 18;
  localparam int NB = 27;
  localparam int FW = NW * WW;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [FW-1:0] result_in = '0;
  logic          load = 1'b0;
  logic          busy;
  logic          done;
  int            n_checks = 0;
  int            n_fail = 0;
  bit            hold_load = 1'b0;

  output_serializer_if tx ();

  output_serializer #(.N_WORDS(NW), .WORD_W(WW)) dut (
    .clk       (clk),
    .reset     (reset),
    .result_in (result_in),
    .load      (load),
    .busy      (busy),
    .done      (done),
    .tx        (tx)
  );

  always #5 clk = ~clk;

  // Expected byte b of a frame: word b/3, byte b%3 of that word, LS byte first.
  function automatic logic [7:0] exp_byte(input logic [FW-1:0] flat, input int b);
    logic [31:0] w;
    int k, j;
    k = b / 3;
    j = b % 3;
    w = 32'(flat[k*WW +: WW]);
    return 8'((w >> (8 * j)) & 32'hFF);
  endfunction

  function automatic logic [FW-1:0] pack(input logic [WW-1:0] w [NW]);
    logic [FW-1:0] f;
    f = '0;
    for (int k = 0; k < NW; k++) f[k*WW +: WW] = w[k];
    return f;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge with the block idle: request a capture of flat.
  task automatic start(input logic [FW-1:0] flat);
    result_in = flat;
    load = 1'b1;
    tx.data_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    if (!hold_load) load = 1'b0;
  endtask

  // Called at the negedge after capture: drains the frame and returns at the
  // negedge of the done cycle having checked that cycle.
  task automatic stream(input logic [FW-1:0] flat, input bit rand_ready,
                        input int inject_at, input logic [FW-1:0] alt);
    int n, cyc;
    bit stalled, injected;
    logic [7:0] last;
    n = 0; cyc = 0; stalled = 0; injected = 0; last = '0;
    while (n < NB && cyc < 1000) begin
      check("valid", 32'(tx.data_valid), 1);
      check("busy", 32'(busy), 1);
      check("done_low", 32'(done), 0);
      check($sformatf("byte%0d", n), 32'(tx.data_out), 32'(exp_byte(flat, n)));
      if (stalled) check("hold", 32'(tx.data_out), 32'(last));
      if (n == inject_at && !injected) begin
        load = 1'b1;
        result_in = alt;
        injected = 1'b1;
      end else if (!hold_load) begin
        load = 1'b0;
      end
      tx.data_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      stalled = !tx.data_ready;
      last = tx.data_out;
      @(posedge clk);
      if (tx.data_ready) n++;
      cyc++;
      @(negedge clk);
    end
    check("transfers", 32'(n), NB);
    check("done_pulse", 32'(done), 1);
    check("end_valid", 32'(tx.data_valid), 0);
    check("end_busy", 32'(busy), 0);
  endtask

  // One cycle after done with no load: still idle, pulse gone.
  task automatic after_done();
    load = 1'b0;
    @(negedge clk);
    check("done_once", 32'(done), 0);
    check("idle_valid", 32'(tx.data_valid), 0);
  endtask

  initial begin
    logic [WW-1:0] w [NW];
    logic [FW-1:0] f_seq, f_pad, f_rnd, f_alt;

    tx.data_ready = 1'b1;
    for (int k = 0; k < NW; k++) w[k] = 18'(k + 1);
    f_seq = pack(w);
    for (int k = 0; k < NW; k++) w[k] = '0;
    w[0] = 18'h3FFFF;
    f_pad = pack(w);
    for (int k = 0; k < NW; k++) w[k] = 18'($urandom);
    f_rnd = pack(w);
    for (int k = 0; k < NW; k++) w[k] = 18'($urandom) | 18'h1;
    f_alt = pack(w);

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_data", 32'(tx.data_out), 0);
    check("rst_valid", 32'(tx.data_valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    reset = 1'b1;
    @(negedge clk);

    // Frame with ready held high
    start(f_seq);
    stream(f_seq, 1'b0, -1, '0);
    after_done();

    // Pad bits go out as zero
    start(f_pad);
    stream(f_pad, 1'b0, -1, '0);
    after_done();

    // Random backpressure, same sequence
    start(f_seq);
    stream(f_seq, 1'b1, -1, '0);
    after_done();

    // Random data with backpressure
    start(f_rnd);
    stream(f_rnd, 1'b1, -1, '0);
    after_done();

    // Load while busy is ignored
    start(f_seq);
    stream(f_seq, 1'b1, 10, f_alt);
    after_done();

    // Back-to-back frames with load held high
    hold_load = 1'b1;
    start(f_rnd);
    stream(f_rnd, 1'b0, 0, f_alt);
    hold_load = 1'b0;
    @(posedge clk);
    @(negedge clk);
    stream(f_alt, 1'b0, -1, '0);
    after_done();

    // Reset mid-frame
    start(f_seq);
    repeat (5) @(negedge clk);
    reset = 1'b0;
    #1;
    check("mid_rst_data", 32'(tx.data_out), 0);
    check("mid_rst_valid", 32'(tx.data_valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_done", 32'(done), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_valid", 32'(tx.data_valid), 0);
      check("post_rst_done", 32'(done), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
